// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StAbort = 2'd2
  } arb_state_e;

  localparam int unsigned WbDatW = 32;
  localparam int unsigned WbAdrW = 32;
  localparam int unsigned WbSelW = 4;

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    int unsigned k;
    k       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr_i) + i) % N;
      if (!valid_o && req_i[k]) begin
        gnt_o[k] = 1'b1;
        idx_o    = IdxW'(k);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port, grant held for the
// whole cycle, watchdog aborts unacknowledged strobes with a bus error.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 3,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*WbAdrW-1:0]   m_adr_i,
  input  logic [N_MASTERS*WbDatW-1:0]   m_dat_i,
  input  logic [N_MASTERS*WbSelW-1:0]   m_sel_i,
  input  logic [N_MASTERS-1:0]          m_we_i,
  input  logic [N_MASTERS-1:0]          m_cyc_i,
  input  logic [N_MASTERS-1:0]          m_stb_i,
  output logic [WbDatW-1:0]             m_dat_o,
  output logic [N_MASTERS-1:0]          m_ack_o,
  output logic [N_MASTERS-1:0]          m_err_o,
  output logic [WbAdrW-1:0]             s_adr_o,
  output logic [WbDatW-1:0]             s_dat_o,
  output logic [WbSelW-1:0]             s_sel_o,
  output logic                          s_we_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  input  logic [WbDatW-1:0]             s_dat_i,
  input  logic                          s_ack_i,
  output logic [N_MASTERS-1:0]          grant_o
);

  localparam int unsigned IdxW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  arb_state_e           state_q;
  logic [N_MASTERS-1:0] grant_q;
  logic [IdxW-1:0]      gidx_q;
  logic [IdxW-1:0]      ptr_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [N_MASTERS-1:0] pick_gnt;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_valid;
  logic                 g_cyc, g_stb, stall, timeout;

  rr_pick #(
    .N    (N_MASTERS),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i   (m_cyc_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;
  assign g_cyc   = m_cyc_i[gidx_q];
  assign g_stb   = m_stb_i[gidx_q];

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    stall   = 1'b0;
    timeout = 1'b0;
    if (state_q == StGrant) begin
      s_adr_o = m_adr_i[32'(gidx_q)*WbAdrW +: WbAdrW];
      s_dat_o = m_dat_i[32'(gidx_q)*WbDatW +: WbDatW];
      s_sel_o = m_sel_i[32'(gidx_q)*WbSelW +: WbSelW];
      s_we_o  = m_we_i[gidx_q];
      s_cyc_o = g_cyc;
      s_stb_o = g_stb;
      m_ack_o[gidx_q] = s_ack_i & g_cyc;
      stall   = g_cyc & g_stb & ~s_ack_i;
      // An ack in the final stalled cycle suppresses the error.
      timeout = stall & (cnt_q == CNT_W'(TIMEOUT - 1));
      m_err_o[gidx_q] = timeout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (pick_valid) begin
            state_q <= StGrant;
            grant_q <= pick_gnt;
            gidx_q  <= pick_idx;
          end
        end
        StGrant: begin
          if (!g_cyc) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= IdxW'(next_idx(32'(gidx_q), N_MASTERS));
            cnt_q   <= '0;
          end else if (timeout) begin
            state_q <= StAbort;
            cnt_q   <= '0;
          end else if (stall) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
          end
        end
        StAbort: begin
          if (!g_cyc) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= IdxW'(next_idx(32'(gidx_q), N_MASTERS));
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Round-robin Wishbone arbiter that shares one slave-side bus port among N_MASTERS requesters: the LM32 instruction port, the LM32 data port, and a future DMA/servo sequencer master.
- Sits between the masters and the address-decoding interconnect.
- Holds a grant for the whole of the granted master's cycle (cyc_i high).
- Runs a watchdog that aborts transactions the slave never acknowledges, answering them with a bus error.

Parameters:
N_MASTERS, 3, number of requesting masters (2..8)
TIMEOUT, 255, cycles with s_stb_o high and no s_ack_i before abort (1..65535)
CNT_W, 16, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
m_adr_i  in  N_MASTERS*32  packed master addresses, master k at [32k+31:32k]
m_dat_i  in  N_MASTERS*32  packed master write data
m_sel_i  in  N_MASTERS*4  packed byte selects
m_we_i  in  N_MASTERS  write enables
m_cyc_i  in  N_MASTERS  cycle requests
m_stb_i  in  N_MASTERS  strobes
m_dat_o  out  32  read data, broadcast to all masters (s_dat_i passthrough)
m_ack_o  out  N_MASTERS  per-master acknowledge
m_err_o  out  N_MASTERS  per-master bus error (watchdog abort)
s_adr_o  out  32  slave address
s_dat_o  out  32  slave write data
s_sel_o  out  4  slave byte selects
s_we_o  out  1  slave write enable
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_dat_i  in  32  slave read data
s_ack_i  in  1  slave acknowledge
grant_o  out  N_MASTERS  one-hot current grant (all zero when idle)

Behaviour:
- Reset (rst low, async): state IDLE, grant_o=0, priority pointer=0, watchdog=0. All s_* outputs are 0 and m_ack_o/m_err_o are 0 immediately, without waiting for a clock edge.
- State IDLE:
  - Search starts at the pointer and takes the first k with m_cyc_i[k]=1, wrapping modulo N_MASTERS.
  - The grant is registered on the next edge and the state moves to GRANT.
  - If no cyc_i is high, stay in IDLE.
  - Latency: cyc_i rising to s_cyc_o high is one clock.
- State GRANT:
  - s_adr_o, s_dat_o, s_sel_o and s_we_o are combinationally muxed from the granted master.
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g].
  - m_ack_o[g] = s_ack_i; all other m_ack_o bits are 0.
  - The grant is held while m_cyc_i[g]=1 across any number of stb/ack beats.
  - When m_cyc_i[g]=0, on the next edge: grant_o=0, pointer=(g+1) mod N_MASTERS, state IDLE.
  - This guarantees one dead cycle between grants and prevents starvation.
- Watchdog:
  - Counts clocks in GRANT with s_stb_o=1 and s_ack_i=0; the counter clears on s_ack_i or when stb is low.
  - When the count reaches TIMEOUT: m_err_o[g] pulses high for exactly one cycle, and state moves to ABORT.
- State ABORT:
  - s_cyc_o and s_stb_o are forced to 0; m_ack_o is 0.
  - A late s_ack_i is ignored.
  - Wait for m_cyc_i[g]=0, then pointer=(g+1) mod N_MASTERS and state IDLE.
- Simultaneous events:
  - s_ack_i in the same cycle the counter would reach TIMEOUT: the ack wins, no error.
  - Granted master drops cyc in the same cycle a new master raises cyc: release first; the new master is granted after the IDLE cycle.
- Ack gating: m_ack_o never asserts for a master whose cyc is low, and never outside GRANT.
- Reset mid-transaction: the bus is released asynchronously and the interrupted master gets neither ack nor err.
- s_cyc_o/s_stb_o are not registered; combinational path is m_cyc_i/m_stb_i -> s_cyc_o/s_stb_o and s_ack_i -> m_ack_o, with no added wait state per beat.

Decomposition:
- Package wb_arb_pkg holds: state encoding (IDLE=2'd0, GRANT=2'd1, ABORT=2'd2), the WB data/address/select width constants (32/32/4), and a function returning the next-index-mod-N.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req[N_MASTERS], ptr.
  - Outputs: one-hot gnt, index, valid.
- Muxing, FSM and watchdog stay in the top module.

Test Plan:
1. Reset: hold rst=0 with m_cyc_i=3'b111 -> grant_o=0 and s_cyc_o=0 throughout; release rst -> master 0 granted one clock later.
2. Single master: master 1 does 4 single reads, slave acks after 2 waits each -> m_ack_o=3'b010 four times, s_adr_o tracks m_adr_i[63:32], grant held until cyc drops.
3. Full contention: all three cyc high continuously, each releasing after one acked beat -> grant order 0,1,2,0 with one IDLE cycle between grants.
4. Pointer wrap: after a grant to master 2 releases, masters 0 and 2 request together -> master 0 granted first.
5. Timeout with TIMEOUT=8: master 0 strobes and the slave never acks -> m_err_o=3'b001 for one cycle at the 8th stalled clock; s_cyc_o=0 in ABORT; ack injected at cycle 10 is not forwarded.
6. Ack/timeout collision with TIMEOUT=8: s_ack_i arrives on the 8th stalled cycle -> m_ack_o[0]=1 and m_err_o stays 0.
